// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder slice.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: combinational read, byte-enabled synchronous write.
// Contents are deliberately not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [BE_W-1:0]                i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [WORD_W-1:0]              i_wdata,
    output logic [WORD_W-1:0]              o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    assign o_rdata = r_mem[i_idx];

    // Commit only the enabled bytes of the addressed word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder arbitrating the core's I and D ports.
// One transaction is outstanding at a time; done/rdata/err are decoded
// from the registered state so reset clears them immediately.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [31:0]       d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              busy
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t              r_state;
    port_t               r_last_grant;
    port_t               r_port;
    logic [3:0]          r_cnt;
    logic [29:0]         r_waddr;
    logic                r_we;
    logic [BE_W-1:0]     r_be;
    logic [WORD_W-1:0]   r_wdata;

    state_t              w_next_state;
    port_t               w_grant;
    logic                w_accept;
    logic                w_in_range;
    logic                w_mem_we;
    logic [WORD_W-1:0]   w_mem_rdata;
    logic                w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};
    assign w_accept           = i_req | d_req;
    assign w_in_range         = (r_waddr[29:IDX_W] == '0);

    // Arbitration: a lone request wins; on contention the port not granted last wins.
    always_comb begin
        w_grant = PORT_I;
        if (i_req && d_req) begin
            w_grant = (r_last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            w_grant = PORT_D;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch, arbitration history and latency counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last_grant <= PORT_I;
            r_port       <= PORT_I;
            r_cnt        <= '0;
            r_waddr      <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
        end else if (r_state == IDLE && w_accept) begin
            r_last_grant <= w_grant;
            r_port       <= w_grant;
            r_cnt        <= LAT_M1;
            r_waddr      <= (w_grant == PORT_D) ? d_addr[31:2] : i_addr[31:2];
            r_we         <= (w_grant == PORT_D) && d_we;
            r_be         <= d_be;
            r_wdata      <= d_wdata;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Next-state and response decode; RESP lasts exactly one cycle.
    always_comb begin
        w_next_state = r_state;
        i_done       = 1'b0;
        i_rdata      = '0;
        d_done       = 1'b0;
        d_rdata      = '0;
        d_err        = 1'b0;
        w_mem_we     = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
                if (r_port == PORT_I) begin
                    i_done  = 1'b1;
                    i_rdata = w_in_range ? w_mem_rdata : '0;
                end else begin
                    d_done   = 1'b1;
                    d_err    = !w_in_range;
                    d_rdata  = (w_in_range && !r_we) ? w_mem_rdata : '0;
                    w_mem_we = w_in_range && r_we;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (r_be),
        .i_idx   (r_waddr[IDX_W-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

endmodule
